// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write-port controller.
// The master side drives requests; the slave side is the arbiter that owns the write port.
interface rf_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [5*NUM_REQ-1:0]          req_addr;
    logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          wr_en;
    logic [4:0]                    wr_addr;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic                          init_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, wr_en, wr_addr, wr_data, init_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, wr_en, wr_addr, wr_data, init_done
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port controller: clears x1..x31 after reset, then shares the
// single write port round-robin among NUM_REQ writeback requesters.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int INIT_ZERO  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rf_wb_arbiter_if.slave   bus
);
    localparam int                PTR_W      = $clog2(NUM_REQ);
    localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]    NUM_REQ_W  = (PTR_W + 1)'(NUM_REQ);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    localparam state_e RESET_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    localparam logic   RESET_DONE  = (INIT_ZERO == 0);

    state_e                 state_q, state_d;
    logic [4:0]             clrCnt_q, clrCnt_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic                   wrEn_q, wrEn_d;
    logic [4:0]             wrAddr_q, wrAddr_d;
    logic [DATA_WIDTH-1:0]  wrData_q, wrData_d;
    logic                   initDone_q, initDone_d;

    logic [2*NUM_REQ-1:0]   validDbl;
    logic [NUM_REQ-1:0]     validRot;
    logic                   anyValid;
    logic [PTR_W-1:0]       offset;
    logic [PTR_W:0]         grantSum;
    logic [PTR_W-1:0]       grantIdx;
    logic [4:0]             selAddr;
    logic [DATA_WIDTH-1:0]  selData;
    logic [NUM_REQ-1:0]     readyVec;

    // Rotate the valid vector so the pointer sits at bit 0; the lowest set bit is the winner.
    always_comb begin
        validDbl = {bus.req_valid, bus.req_valid};
        validRot = NUM_REQ'(validDbl >> ptr_q);
        anyValid = |bus.req_valid;
        offset   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (validRot[k]) begin
                offset = PTR_W'(k);
            end
        end
        grantSum = {1'b0, ptr_q} + {1'b0, offset};
        if (grantSum >= NUM_REQ_W) begin
            grantSum = grantSum - NUM_REQ_W;
        end
        grantIdx = grantSum[PTR_W-1:0];

        selAddr  = '0;
        selData  = '0;
        readyVec = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grantIdx == PTR_W'(k)) begin
                selAddr     = bus.req_addr[5*k +: 5];
                selData     = bus.req_data[DATA_WIDTH*k +: DATA_WIDTH];
                readyVec[k] = anyValid;
            end
        end
    end

    assign bus.req_ready = (state_q == ST_RUN) ? readyVec : '0;
    assign bus.wr_en     = wrEn_q;
    assign bus.wr_addr   = wrAddr_q;
    assign bus.wr_data   = wrData_q;
    assign bus.init_done = initDone_q;

    always_comb begin
        state_d    = state_q;
        clrCnt_d   = clrCnt_q;
        ptr_d      = ptr_q;
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        initDone_d = initDone_q;
        case (state_q)
            ST_INIT: begin
                wrEn_d   = 1'b1;
                wrAddr_d = clrCnt_q;
                wrData_d = '0;
                clrCnt_d = clrCnt_q + 5'd1;
                if (clrCnt_q == 5'd31) begin
                    state_d    = ST_RUN;
                    initDone_d = 1'b1;
                end
            end
            ST_RUN: begin
                // A write to x0 still completes the handshake but never reaches the file.
                if (anyValid) begin
                    wrEn_d   = (selAddr != 5'd0);
                    wrAddr_d = selAddr;
                    wrData_d = selData;
                    ptr_d    = (grantIdx == LAST_IDX) ? '0 : grantIdx + PTR_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RESET_STATE;
            clrCnt_q   <= 5'd1;
            ptr_q      <= '0;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            initDone_q <= RESET_DONE;
        end else begin
            state_q    <= state_d;
            clrCnt_q   <= clrCnt_d;
            ptr_q      <= ptr_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            initDone_q <= initDone_d;
        end
    end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus protocol-legal random
// requests, all compared against a cycle-level reference model of the arbitration rules.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int NR = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic rstZ_n;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
    rf_wb_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) busZ ();

    rf_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_ZERO(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rf_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .INIT_ZERO(0)) dutZ (
        .clk   (clk),
        .rst_n (rstZ_n),
        .bus   (busZ)
    );

    int checks = 0;
    int errors = 0;

    bit              mKnown = 1'b0;
    bit              mInit;
    int              mCnt;
    int              mPtr;
    logic            expWrEn;
    logic [4:0]      expWrAddr;
    logic [DW-1:0]   expWrData;
    logic            expInitDone;
    int              lastGrant;

    logic [NR-1:0]   reqValid;
    logic [4:0]      reqAddr [NR];
    logic [DW-1:0]   reqData [NR];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pickGrant(input logic [NR-1:0] v, input int ptr);
        int idx;
        for (int k = 0; k < NR; k++) begin
            idx = (ptr + k) % NR;
            if (((v >> idx) & NR'(1)) != '0) return idx;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic rstVal);
        rst_n = rstVal;
        bus.req_valid = reqValid;
        for (int i = 0; i < NR; i++) begin
            bus.req_addr[5*i +: 5]   = reqAddr[i];
            bus.req_data[DW*i +: DW] = reqData[i];
        end
    endtask

    // Entered one time unit after a posedge; returns one time unit after the next posedge.
    task automatic stepCycle(input string tag);
        int            g;
        logic [NR-1:0] expReady;
        #1;
        g = -1;
        if (mKnown && !mInit) g = pickGrant(reqValid, mPtr);
        expReady = (g >= 0) ? (NR'(1) << g) : '0;
        if (mKnown) checkOutput({tag, "/ready"}, 64'(bus.req_ready), 64'(expReady));
        lastGrant = g;
        @(posedge clk);
        if (!rst_n) begin
            mKnown = 1'b1; mInit = 1'b1; mCnt = 1; mPtr = 0;
            expWrEn = 1'b0; expWrAddr = '0; expWrData = '0; expInitDone = 1'b0;
            lastGrant = -1;
        end else if (mKnown) begin
            if (mInit) begin
                expWrEn = 1'b1; expWrAddr = 5'(mCnt); expWrData = '0;
                if (mCnt == 31) begin
                    mInit = 1'b0; expInitDone = 1'b1;
                end
                mCnt++;
            end else if (g >= 0) begin
                expWrEn   = (reqAddr[g] != 5'd0);
                expWrAddr = reqAddr[g];
                expWrData = reqData[g];
                mPtr      = (g + 1) % NR;
            end else begin
                expWrEn = 1'b0;
            end
        end
        #1;
        if (mKnown) begin
            checkOutput({tag, "/wr_en"},     64'(bus.wr_en),     64'(expWrEn));
            checkOutput({tag, "/wr_addr"},   64'(bus.wr_addr),   64'(expWrAddr));
            checkOutput({tag, "/wr_data"},   64'(bus.wr_data),   64'(expWrData));
            checkOutput({tag, "/init_done"}, 64'(bus.init_done), 64'(expInitDone));
        end
    endtask

    task automatic randomRequests();
        for (int i = 0; i < NR; i++) begin
            if (reqValid[i] && lastGrant != i) begin
                if ($urandom_range(9) == 0) reqValid[i] = 1'b0;
            end else begin
                reqValid[i] = ($urandom_range(9) < 6);
                reqAddr[i]  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                reqData[i]  = $urandom;
            end
        end
    endtask

    initial begin
        int expGrantSeq [6];
        int expAddrSeq  [6];
        expGrantSeq = '{0, 1, 2, 0, 1, 2};
        expAddrSeq  = '{5, 6, 7, 5, 6, 7};

        reqValid = '0;
        for (int i = 0; i < NR; i++) begin
            reqAddr[i] = '0;
            reqData[i] = '0;
        end
        rstZ_n         = 1'b0;
        busZ.req_valid = '0;
        busZ.req_addr  = '0;
        busZ.req_data  = '0;
        applyStimulus(1'b0);
        stepCycle("rst0");

        // The INIT_ZERO=0 instance comes out of reset already running.
        checkOutput("z/init_done", 64'(busZ.init_done), 64'd1);
        checkOutput("z/wr_en_rst", 64'(busZ.wr_en), 64'd0);
        rstZ_n = 1'b1;
        busZ.req_valid = 3'b001;
        busZ.req_addr  = 15'd9;
        busZ.req_data  = {32'h0, 32'h0, 32'h0000_1234};
        #1;
        checkOutput("z/ready", 64'(busZ.req_ready), 64'b001);
        stepCycle("rst1");
        busZ.req_valid = '0;
        checkOutput("z/wr_en",   64'(busZ.wr_en),   64'd1);
        checkOutput("z/wr_addr", 64'(busZ.wr_addr), 64'd9);
        checkOutput("z/wr_data", 64'(busZ.wr_data), 64'h1234);
        stepCycle("rst2");
        checkOutput("z/wr_en_idle", 64'(busZ.wr_en), 64'd0);

        // Requests held during INIT must never be granted.
        reqValid = 3'b111;
        reqAddr[0] = 5'd5; reqAddr[1] = 5'd6; reqAddr[2] = 5'd7;
        reqData[0] = 32'hA0; reqData[1] = 32'hA1; reqData[2] = 32'hA2;
        applyStimulus(1'b1);
        for (int i = 1; i <= 10; i++) stepCycle("init_a");
        applyStimulus(1'b0);
        stepCycle("init_abort");
        checkOutput("abort/wr_en",     64'(bus.wr_en),     64'd0);
        checkOutput("abort/init_done", 64'(bus.init_done), 64'd0);
        applyStimulus(1'b1);
        for (int i = 1; i <= 31; i++) begin
            stepCycle("init_b");
            checkOutput("init_b/addr_seq", 64'(bus.wr_addr), 64'(i));
        end

        for (int i = 0; i < 6; i++) begin
            stepCycle("all_valid");
            checkOutput("all_valid/grant", 64'(lastGrant), 64'(expGrantSeq[i]));
            checkOutput("all_valid/addr",  64'(bus.wr_addr), 64'(expAddrSeq[i]));
        end

        reqValid = 3'b010;
        reqAddr[1] = 5'd0;
        reqData[1] = 32'hDEADBEEF;
        applyStimulus(1'b1);
        stepCycle("x0_write");
        checkOutput("x0_write/wr_en", 64'(bus.wr_en), 64'd0);

        reqValid = 3'b001;
        applyStimulus(1'b1);
        stepCycle("req0_only");
        reqValid = 3'b101;
        applyStimulus(1'b1);
        stepCycle("ptr1_pair");
        checkOutput("ptr1_pair/grant", 64'(lastGrant), 64'd2);
        reqValid = 3'b001;
        applyStimulus(1'b1);
        stepCycle("ptr1_second");
        checkOutput("ptr1_second/grant", 64'(lastGrant), 64'd0);
        reqValid = 3'b000;
        applyStimulus(1'b1);
        stepCycle("idle");
        checkOutput("idle/wr_en", 64'(bus.wr_en), 64'd0);

        for (int n = 0; n < 400; n++) begin
            randomRequests();
            applyStimulus(n == 200 ? 1'b0 : 1'b1);
            stepCycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port controller for the 32×DATA_WIDTH register file. It owns the register file's single synchronous write port (wr_en / wr_addr / wr_data) and shares it round-robin among NUM_REQ writeback requesters using a valid/ready handshake. After reset it runs a clear sequence that writes zero to registers 1..31 before accepting requests. It sits between the CPU writeback sources (ALU, load unit, debug) and the register file.

## Interface
- DATA_WIDTH, 32, register data width
- NUM_REQ, 3, number of writeback requesters (2..8)
- INIT_ZERO, 1, 1 = run the post-reset clear sequence; 0 = enter RUN directly

- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk
- req_valid  in  NUM_REQ  requester i has a write pending
- req_addr  in  5*NUM_REQ  destination register of requester i, bits [5i+4:5i]
- req_data  in  DATA_WIDTH*NUM_REQ  write data of requester i, slice i
- req_ready  out  NUM_REQ  one-hot grant, combinational from state, pointer and req_valid
- wr_en  out  1  registered write enable to the register file
- wr_addr  out  5  registered write address
- wr_data  out  DATA_WIDTH  registered write data
- init_done  out  1  registered; high once the clear sequence completes

## Operation
- States: INIT and RUN.
- rst_n low at a posedge forces:
  - state = INIT if INIT_ZERO = 1, else RUN
  - clear counter = 1
  - rr pointer = 0
  - wr_en = 0, wr_addr = 0, wr_data = 0
  - init_done = 0 if INIT_ZERO = 1, else 1
- INIT:
  - req_ready = 0 for all requesters.
  - Each posedge registers wr_en = 1, wr_addr = counter, wr_data = 0, then increments the counter.
  - The posedge that registers address 31 also moves the state to RUN and sets init_done = 1.
- RUN, arbitration:
  - The grant goes to the first i with req_valid[i] = 1, scanning from the rr pointer upward with wrap modulo NUM_REQ.
  - req_ready[i] = 1 for the granted requester only. At most one bit of req_ready is high.
  - req_ready is independent of req_addr and req_data.
- RUN, transfer:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - At the next posedge: wr_en = (req_addr_i != 0), wr_addr = req_addr_i, wr_data = req_data_i, pointer = (i+1) mod NUM_REQ.
- Writes to x0: the handshake completes normally, but wr_en is 0, so x0 remains hardwired to 0.
- No valid requester in RUN: the next posedge registers wr_en = 0. wr_addr, wr_data and the pointer hold.
- A requester must hold req_valid, req_addr and req_data stable until it is granted. Deasserting req_valid before the grant withdraws the request; this is legal and produces no write.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Reset asserted mid-INIT or mid-RUN aborts the current activity. Reset values apply at that edge, and a pending accepted write that was not yet registered is lost.

## Timing
- Write latency: transfer cycle N → wr_* driven during cycle N+1. The register file commits the write at the end of N+1 (posedge N+2).
- Throughput: one write per cycle in RUN.
- INIT duration, counted from the first posedge with rst_n high:
  - Posedges 1..31 register wr_addr = 1..31 with wr_en = 1.
  - req_ready may first be high in the cycle following posedge 31.
- init_done rises at posedge 31 and stays high until the next reset.
- rst_n low for a single posedge is sufficient.

## Test plan
- Reset, INIT_ZERO = 1, no requests → wr_en high for exactly 31 cycles with wr_addr = 1,2,…,31 and wr_data = 0; init_done rises on the same edge as addr 31; req_ready = 0 throughout INIT.
- RUN, NUM_REQ = 3, all req_valid held high with addrs 5, 6, 7 → grants cycle 0,1,2,0,…; wr_addr sequence 5,6,7,5 one cycle after each grant; exactly one req_ready bit high per cycle.
- Single requester 1 writes addr 0, data 0xDEADBEEF → req_ready[1] = 1, next cycle wr_en = 0, pointer advances to 2.
- Requesters 0 and 2 valid, pointer = 1 → requester 2 granted first, then 0; an idle cycle between grants registers wr_en = 0.
- rst_n pulsed low for one cycle mid-INIT (after addr 10) → wr_en = 0 and init_done = 0 at that edge; the clear sequence restarts at addr 1.
- INIT_ZERO = 0 → init_done = 1 and wr_en = 0 out of reset; a request in the first cycle after reset is granted immediately, and the write appears one cycle later.
